encoder_4_2_rr: RTL and testbench

Sequential 4-to-2 encoder that is the inverse of the team's 2-to-4 enable-gated decoder. It collects four request lines into sticky pending bits and encodes them back to a 2-bit index. Pending requests are issued one per cycle, in round-robin order, over a valid/ready handshake. It sits upstream of the decoder so that a decoded one-hot select can be regenerated from the returned index.

---
 rtl/encoder_4_2_rr_if.sv | 20 ++
 rtl/encoder_4_2_rr.sv | 69 ++++++
 tb/tb_encoder_4_2_rr.sv | 116 +++++++++++
 3 files changed

// File: rtl/encoder_4_2_rr_if.sv
// rtl/encoder_4_2_rr_if.sv - request/grant bundle for the round-robin 4-to-2 encoder
interface encoder_4_2_rr_if;
  logic       en;
  logic [3:0] d;
  logic       ready;
  logic [1:0] code_out;
  logic       valid;
  logic [3:0] pending;
  logic       overflow;

  modport master (
    output en, d, ready,
    input  code_out, valid, pending, overflow
  );

  modport slave (
    input  en, d, ready,
    output code_out, valid, pending, overflow
  );
endinterface

// File: rtl/encoder_4_2_rr.sv
// rtl/encoder_4_2_rr.sv - sticky request collector issuing 2-bit codes round-robin over valid/ready
module encoder_4_2_rr (
  input  logic              clk,
  input  logic              reset,
  encoder_4_2_rr_if.slave   bus
);

  logic [3:0] r_pending;
  logic [1:0] r_code;
  logic       r_valid;
  logic [1:0] r_last;
  logic       r_overflow;

  logic       w_acc;
  logic [3:0] w_clr;
  logic [3:0] w_set;
  logic [3:0] w_avail;
  logic       w_slot_free;
  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_cand;

  always_comb begin
    w_acc       = r_valid & bus.ready;
    w_clr       = w_acc ? (4'b0001 << r_code) : 4'b0000;
    w_set       = bus.en ? bus.d : 4'b0000;
    w_avail     = r_pending & ~w_clr;
    w_slot_free = ~r_valid | bus.ready;
    w_found     = 1'b0;
    w_pick      = r_last;
    w_cand      = r_last;
    // Walk from the farthest candidate back to last+1 so the nearest one wins.
    for (int i = 3; i >= 0; i--) begin
      w_cand = r_last + 2'(i + 1);
      if (w_avail[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= 4'b0000;
      r_code     <= 2'b00;
      r_valid    <= 1'b0;
      r_last     <= 2'b11;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_clr) | w_set;
      r_overflow <= |(w_set & r_pending & ~w_clr);
      if (w_slot_free) begin
        if (w_found) begin
          r_code  <= w_pick;
          r_last  <= w_pick;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.code_out = r_code;
  assign bus.valid    = r_valid;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_encoder_4_2_rr.sv
// tb/tb_encoder_4_2_rr.sv - directed-vector bench for encoder_4_2_rr
module tb_encoder_4_2_rr;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  encoder_4_2_rr_if bus ();

  encoder_4_2_rr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] d, input logic rdy);
    bus.en    = en;
    bus.d     = d;
    bus.ready = rdy;
  endtask

  task automatic chk_out(input string tag, input int v, input int c, input int p, input int o);
    chk({tag, ".valid"}, int'(bus.valid), v);
    if (v == 1) chk({tag, ".code"}, int'(bus.code_out), c);
    chk({tag, ".pending"}, int'(bus.pending), p);
    chk({tag, ".overflow"}, int'(bus.overflow), o);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    do_reset();
    chk("rst.code", int'(bus.code_out), 0);
    chk_out("rst", 0, 0, 4'b0000, 0);

    // Single request on line 2
    drive(1'b1, 4'b0100, 1'b1); tick(); chk_out("single.k", 0, 0, 4'b0100, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("single.k1", 1, 2, 4'b0100, 0);
    tick();                             chk_out("single.k2", 0, 0, 4'b0000, 0);

    // Burst from reset priority
    do_reset();
    drive(1'b1, 4'b1111, 1'b1); tick(); chk_out("burst.0", 0, 0, 4'b1111, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("burst.g0", 1, 0, 4'b1111, 0);
    tick();                             chk_out("burst.g1", 1, 1, 4'b1110, 0);
    tick();                             chk_out("burst.g2", 1, 2, 4'b1100, 0);
    tick();                             chk_out("burst.g3", 1, 3, 4'b1000, 0);
    tick();                             chk_out("burst.end", 0, 0, 4'b0000, 0);

    // Backpressure
    drive(1'b1, 4'b0010, 1'b0); tick(); chk_out("bp.req", 0, 0, 4'b0010, 0);
    drive(1'b0, 4'b0000, 1'b0); tick(); chk_out("bp.grant", 1, 1, 4'b0010, 0);
    tick();                             chk_out("bp.hold", 1, 1, 4'b0010, 0);
    drive(1'b1, 4'b1000, 1'b0); tick(); chk_out("bp.stall_req", 1, 1, 4'b1010, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("bp.next", 1, 3, 4'b1000, 0);
    tick();                             chk_out("bp.end", 0, 0, 4'b0000, 0);

    // Round-robin after last=00
    do_reset();
    drive(1'b1, 4'b0001, 1'b1); tick(); chk_out("rr.req0", 0, 0, 4'b0001, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("rr.g00", 1, 0, 4'b0001, 0);
    tick();                             chk_out("rr.idle", 0, 0, 4'b0000, 0);
    drive(1'b1, 4'b0011, 1'b1); tick(); chk_out("rr.req", 0, 0, 4'b0011, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("rr.first", 1, 1, 4'b0011, 0);
    tick();                             chk_out("rr.second", 1, 0, 4'b0001, 0);
    tick();                             chk_out("rr.end", 0, 0, 4'b0000, 0);

    // Overflow while stalled, then collision with an accept
    drive(1'b1, 4'b0001, 1'b0); tick(); chk_out("ov.req", 0, 0, 4'b0001, 0);
    drive(1'b0, 4'b0000, 1'b0); tick(); chk_out("ov.grant", 1, 0, 4'b0001, 0);
    drive(1'b1, 4'b0001, 1'b0); tick(); chk_out("ov.hit", 1, 0, 4'b0001, 1);
    drive(1'b0, 4'b0000, 1'b0); tick(); chk_out("ov.pulse_end", 1, 0, 4'b0001, 0);
    drive(1'b1, 4'b0001, 1'b1); tick(); chk_out("ov.acc_same", 0, 0, 4'b0001, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("ov.reissue", 1, 0, 4'b0001, 0);
    tick();                             chk_out("ov.end", 0, 0, 4'b0000, 0);

    // Enable low ignores d
    drive(1'b0, 4'b1111, 1'b1); tick(); chk_out("en0.a", 0, 0, 4'b0000, 0);
    tick();                             chk_out("en0.b", 0, 0, 4'b0000, 0);

    // Reset mid-transfer
    drive(1'b1, 4'b1110, 1'b0); tick(); chk_out("mid.req", 0, 0, 4'b1110, 0);
    drive(1'b0, 4'b0000, 1'b0); tick(); chk_out("mid.grant", 1, 1, 4'b1110, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid.rst.code", int'(bus.code_out), 0);
    chk_out("mid.rst", 0, 0, 4'b0000, 0);
    drive(1'b1, 4'b1111, 1'b1); tick(); chk_out("post.req", 0, 0, 4'b1111, 0);
    drive(1'b0, 4'b0000, 1'b1); tick(); chk_out("post.first", 1, 0, 4'b1111, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
